lse_accum_seq: RTL
==================

# lse_accum_seq

Sequencer that streams a vector of 8-bit exponents through the pairwise log-sum-exp step of the pseudo-softmax adder and returns the accumulated max-plus-correction exponent. It sits ahead of the normalisation stage. One element is accepted per cycle over a valid/ready input, and the running accumulator is fed back as the second step operand. It owns the step datapath, the element counter, saturation and the output handshake.

## Interface
- `LEN_W`, default 5: width of `len`. Maximum vector length is 2^(LEN_W-1) = 16.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: begin a vector. Sampled only in IDLE.
- `len`, in, LEN_W: element count, 0..16. Sampled with `start`. Values above 16 are clamped to 16.
- `in_valid`, in, 1: `in_exp` valid.
- `in_ready`, out, 1: sequencer accepts `in_exp`.
- `in_exp`, in, 8: unsigned biased exponent.
- `out_valid`, out, 1: result valid.
- `out_ready`, in, 1: consumer accepts result.
- `out_exp`, out, 8: accumulated exponent.
- `out_sat`, out, 1: saturation occurred during this vector.
- `busy`, out, 1: asserted in any state other than IDLE.

## Operation
- Step function: `step(a,b) = max(a,b) + (a==b ? 1 : 0)`.
  - Computed 9-bit, then clamped to 255.
  - Clamping sets the sticky `sat` flag.
  - Difference is taken as a 9-bit signed `a-b`, then absolute value. The correction is `1 >> |d|`, so it is non-zero only when `d = 0`.
- States: IDLE, FIRST, ACCUM, DONE.
- IDLE
  - `in_ready=0`, `out_valid=0`.
  - `start=1` with `len=0`: go to DONE with `acc=0`, `sat=0`.
  - `start=1` with `len>=1`: latch `len` into `remain`, clear `sat`, go to FIRST.
- FIRST
  - `in_ready=1`.
  - On `in_valid`: `acc <= in_exp` (no step applied), `remain <= remain-1`.
  - Go to DONE if `remain==1`, else go to ACCUM.
- ACCUM
  - `in_ready=1`.
  - On handshake: `acc <= step(acc, in_exp)`, `remain <= remain-1`.
  - Go to DONE on the last element.
- DONE
  - `out_valid=1`, `out_exp=acc`, `out_sat=sat`.
  - Outputs are held stable while `out_ready=0`.
  - On `out_ready=1`: go to IDLE.
- `start` outside IDLE is ignored: no state, counter or flag change.
- `in_valid` while `in_ready=0` is ignored and nothing is consumed.
- Input gaps (`in_valid=0`) stall the sequencer with no state change.
- Reset mid-vector: everything returns immediately to reset values. A partial vector is discarded and no output is produced.

## Timing
- Reset values: state=IDLE, `acc=0`, `remain=0`, `sat=0`. Outputs: `in_ready=0`, `out_valid=0`, `out_exp=0`, `out_sat=0`, `busy=0`.
- `in_ready` is a registered-state decode. It rises the cycle after `start` is sampled.
- Throughput: 1 element/cycle with no bubbles.
- Latency: `out_valid` rises the cycle after the last input handshake. With `len=0`, it rises the cycle after `start`.
- Minimum turnaround: a new `start` is accepted the cycle after the output handshake.
- Step datapath is single-cycle combinational between `acc` and the register input. No multicycle paths.

## Structure
- Shared package `psm_pkg`:
  - state enum `lse_state_t` (IDLE, FIRST, ACCUM, DONE);
  - `EXP_W=8`;
  - `EXP_MAX=8'hFF`;
  - `LSE_MAX_LEN=16`.
- One sub-module, `lse_step`: combinational.
  - Inputs `a[7:0]`, `b[7:0]`.
  - Outputs `y[7:0]` (clamped result) and `sat`.
  - Reused later by the tree-reduction variant.
- Top module holds the FSM, the `remain` counter, `acc`, the sticky `sat` and the output registers.

## Test plan
- `len=4`, inputs 10,10,11,5 back-to-back:
  - `acc` goes 10, 11, 12, 12;
  - `out_exp=12`, `out_sat=0`, `out_valid` at cycle after 4th handshake.
- `len=1`, input 200 → `out_exp=200`, `out_sat=0`. No step is applied to the single element.
- `len=2`, inputs 255,255 → `out_exp=255`, `out_sat=1`.
- `len=0` → `out_valid` one cycle after `start`, `out_exp=0`, and `in_ready` never asserts.
- Backpressure and ignored inputs, `len=3`, inputs 7,7,9:
  - `in_valid` gaps of 2 cycles;
  - `out_ready=0` for 5 cycles after result;
  - `start` pulsed while busy.
  - Required: `out_exp=9` stable throughout, `out_sat=0`, and the stray `start` has no effect.
- `rst_n` low after 2 of 4 elements → outputs at reset values immediately. A following `len=2`, inputs 3,4 → `out_exp=4`.

Source files
------------

// File: rtl/psm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | psm_pkg : shared types and constants for the pseudo-softmax    |
// | Revision: 1.0                                                  |
// +----------------------------------------------------------------+
package psm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        ACCUM = 2'd2,
        DONE  = 2'd3
    } lse_state_t;

    localparam int             EXP_W       = 8;
    localparam logic [EXP_W-1:0] EXP_MAX   = 8'hFF;
    localparam int             LSE_MAX_LEN = 16;

endpackage

`default_nettype wire

// File: rtl/lse_step.sv
`default_nettype none
// +----------------------------------------------------------------+
// | lse_step : pairwise log-sum-exp step, max(a,b) + (a==b), clamp |
// | Revision: 1.0                                                  |
// +----------------------------------------------------------------+
module lse_step
    import psm_pkg::*;
(
    input  logic [EXP_W-1:0] a,
    input  logic [EXP_W-1:0] b,
    output logic [EXP_W-1:0] y,
    output logic             sat
);

    logic [EXP_W:0]   w_diff;
    logic [EXP_W:0]   w_abs;
    logic [EXP_W:0]   w_corr;
    logic [EXP_W-1:0] w_max;
    logic [EXP_W:0]   w_sum;

    // Correction is 1 >> |a-b|, which is non-zero only for equal operands.
    assign w_diff = {1'b0, a} - {1'b0, b};
    assign w_abs  = w_diff[EXP_W] ? (~w_diff + 1'b1) : w_diff;
    assign w_corr = {{EXP_W{1'b0}}, 1'b1} >> w_abs;
    assign w_max  = (a > b) ? a : b;
    assign w_sum  = {1'b0, w_max} + w_corr;

    assign sat = w_sum[EXP_W];
    assign y   = sat ? EXP_MAX : w_sum[EXP_W-1:0];

endmodule

`default_nettype wire

// File: rtl/lse_accum_seq.sv
`default_nettype none
// +----------------------------------------------------------------+
// | lse_accum_seq : streams exponents through lse_step, accumulates|
// | Revision: 1.0                                                  |
// +----------------------------------------------------------------+
module lse_accum_seq
    import psm_pkg::*;
#(
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] in_exp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_sat,
    output logic             busy
);

    localparam logic [LEN_W-1:0] c_MAX_LEN = {1'b1, {(LEN_W-1){1'b0}}};
    localparam logic [LEN_W-1:0] c_ONE     = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] c_ZERO    = '0;

    lse_state_t       state_q, state_d;
    logic [EXP_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] remain_q, remain_d;
    logic             sat_q, sat_d;

    logic [EXP_W-1:0] w_step_y;
    logic             w_step_sat;
    logic [LEN_W-1:0] w_len;
    logic             w_last;

    lse_step u_step (
        .a   (acc_q),
        .b   (in_exp),
        .y   (w_step_y),
        .sat (w_step_sat)
    );

    assign w_len  = (len > c_MAX_LEN) ? c_MAX_LEN : len;
    assign w_last = (remain_q == c_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            remain_q <= '0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            remain_q <= remain_d;
            sat_q    <= sat_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        remain_d = remain_q;
        sat_d    = sat_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sat_d = 1'b0;
                    if (w_len == c_ZERO) begin
                        acc_d   = '0;
                        state_d = DONE;
                    end else begin
                        remain_d = w_len;
                        state_d  = FIRST;
                    end
                end
            end
            FIRST: begin
                // The first element seeds the accumulator without a step.
                if (in_valid) begin
                    acc_d    = in_exp;
                    remain_d = remain_q - c_ONE;
                    state_d  = w_last ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d    = w_step_y;
                    sat_d    = sat_q | w_step_sat;
                    remain_d = remain_q - c_ONE;
                    if (w_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == FIRST) || (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_exp   = acc_q;
    assign out_sat   = sat_q;

endmodule

`default_nettype wire
